// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZCV flag bit positions and
// flag-write select bits used by the condition/writeback stage.
package cpu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Bit positions match the ALU NZCV output bus.
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam int FW_CV = 0;
    localparam int FW_NZ = 1;

endpackage

// File: rtl/cpu_cond_check.sv
// Combinational evaluation of an instruction condition field against the
// stored NZCV flags.
module cpu_cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            // The reserved encoding never executes.
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_cond_unit.sv
// Execute-to-writeback stage: NZCV flags register, condition gating of
// write enables, pipeline register and saturating condition-fail counter.
module cpu_cond_unit #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              valid_in,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic [3:0]        cond_in,
    input  logic [1:0]        flag_w_in,
    input  logic [3:0]        alu_flags_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              reg_write_in,
    input  logic              mem_write_in,
    input  logic              pc_write_in,
    output logic              carry_out,
    output logic [3:0]        flags_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] result_out,
    output logic [RD_W-1:0]   rd_out,
    output logic              reg_write_out,
    output logic              mem_write_out,
    output logic              pc_write_out,
    output logic [CNT_W-1:0]  cond_fail_cnt_out
);

    import cpu_pkg::*;

    logic [3:0]       flags;
    logic [CNT_W-1:0] fail_cnt;
    logic             cond_ex;
    logic             adv;
    logic             fire;
    logic             cond_fail;

    cpu_cond_check u_cond_check (
        .cond    (cond_in),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign adv       = !stall_in && !flush_in;
    assign fire      = valid_in && adv && cond_ex;
    assign cond_fail = valid_in && adv && !cond_ex;

    assign flags_out         = flags;
    assign carry_out         = flags[FLAG_C];
    assign cond_fail_cnt_out = fail_cnt;

    // No forwarding: a flag write is seen by the following instruction.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            flags <= 4'b0000;
        end else if (fire) begin
            if (flag_w_in[FW_NZ]) begin
                flags[FLAG_N] <= alu_flags_in[FLAG_N];
                flags[FLAG_Z] <= alu_flags_in[FLAG_Z];
            end
            if (flag_w_in[FW_CV]) begin
                flags[FLAG_C] <= alu_flags_in[FLAG_C];
                flags[FLAG_V] <= alu_flags_in[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_out     <= 1'b0;
            result_out    <= '0;
            rd_out        <= '0;
            reg_write_out <= 1'b0;
            mem_write_out <= 1'b0;
            pc_write_out  <= 1'b0;
        end else if (flush_in) begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            mem_write_out <= 1'b0;
            pc_write_out  <= 1'b0;
        end else if (!stall_in) begin
            valid_out     <= valid_in;
            result_out    <= result_in;
            rd_out        <= rd_in;
            reg_write_out <= valid_in && cond_ex && reg_write_in;
            mem_write_out <= valid_in && cond_ex && mem_write_in;
            pc_write_out  <= valid_in && cond_ex && pc_write_in;
        end
    end

    // Saturates rather than wraps so a long run of failures stays visible.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fail_cnt <= '0;
        end else if (cond_fail && (fail_cnt != {CNT_W{1'b1}})) begin
            fail_cnt <= fail_cnt + 1'b1;
        end
    end

endmodule
